store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have port clk, input, 1 -- single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 -- synchronous, active-low reset.
REQ-003 SHALL have port s_valid, input, 1 -- store request present.
REQ-004 SHALL have port s_ready, output, 1 -- queue can accept a request.
REQ-005 SHALL have port s_addr, input, 32 -- byte address of the store.
REQ-006 SHALL have port s_mode, input, ldst_mode -- store width: byte, half or word member.
REQ-007 SHALL have port s_data, input, 32 -- store data, right-aligned.
REQ-008 SHALL have port ra, output, 32 -- memory read address, word-aligned (ra[1:0]=0).
REQ-009 SHALL have port rd, input, 32 -- combinational memory read data for ra.
REQ-010 SHALL have port we, output, 1 -- memory write enable.
REQ-011 SHALL have port wa, output, 32 -- memory write address, word-aligned.
REQ-012 SHALL have port wm, output, ldst_mode -- always the word member.
REQ-013 SHALL have port wd, output, 32 -- merged full word to write.
REQ-014 SHALL have port busy, output, 1 -- queue non-empty or FSM not IDLE.
REQ-015 SHALL have port done, output, 1 -- one-cycle pulse per completed store.
REQ-016 SHALL have port err, output, 1 -- sticky misalignment flag (see Configuration).

Function
REQ-017 SHALL buffer requests in a 2-entry FIFO; a request is accepted on a cycle with s_valid && s_ready.
REQ-018 SHALL drive s_ready = 1 when fewer than 2 entries are held; s_ready=0 when full, even if an entry pops that cycle.
REQ-019 SHALL permit simultaneous push and pop when not full; count stays unchanged.
REQ-020 SHALL run FSM states IDLE, READ, WRITE.
REQ-021 IDLE: if FIFO non-empty, pop head; byte/half -> READ, word -> WRITE.
REQ-022 READ: ra = {addr[31:2],2'b00}; register rd into a merge buffer; -> WRITE next cycle.
REQ-023 WRITE: we=1 for exactly one cycle; wa = {addr[31:2],2'b00}; done=1 in the same cycle; -> IDLE.
REQ-024 Merge rule: byte replaces lane addr[1:0] with s_data[7:0]; half replaces lane addr[1] (bits 15:0 or 31:16) with s_data[15:0]; word writes s_data unmodified; other lanes are taken from the READ capture.
REQ-025 Latency from acceptance into an empty idle unit to the we cycle: word 2 cycles, byte/half 3 cycles.
REQ-026 Back-to-back stores to the same word SHALL see the prior write; each READ occurs at least one cycle after the prior WRITE.
REQ-027 An unrecognized s_mode value SHALL be treated as word.
REQ-028 ra SHALL be 0 in IDLE and WRITE; we, wa and wd SHALL be 0 outside WRITE.

Reset
REQ-029 With rst_n=0 at a rising edge: FIFO emptied, FSM -> IDLE, merge buffer 0, err=0.
REQ-030 During and after reset: s_ready=1, we=0, done=0, busy=0, ra=wa=wd=0.
REQ-031 Reset during READ or WRITE SHALL abort the store with no we pulse on the following cycle.

Configuration
REQ-032 Macro STORE_UNIT_MISALIGN_TRAP_EN.
REQ-033 Defined: a half store with addr[0]=1 or a word store with addr[1:0]!=0 SHALL be dropped, with no we or done, err set until reset, and the FSM returned to IDLE after one cycle.
REQ-034 Undefined: misaligned addresses SHALL have their low bits ignored (half uses addr[1]; word uses the aligned word), and err SHALL be tied to 0.

Verification
REQ-035 Word store addr=0xFC, data=0x00123456 into an idle unit -> we at cycle+2, wa=0xFC, wd=0x00123456, done pulse.
REQ-036 Byte store addr=0x101, data=0xAB, with memory 0x11223344 -> READ, then wd=0x1122AB44 at cycle+3.
REQ-037 Half store addr=0x102, data=0xBEEF, with memory 0x11223344 -> wd=0xBEEF3344.
REQ-038 Three back-to-back requests held valid -> s_ready drops after two are accepted; all three complete in order; three done pulses.
REQ-039 Byte stores 0x01 to addr 0x0 then 0x02 to addr 0x1, starting from memory 0 -> final memory word 0x00000201.
REQ-040 Half store to 0x3 -> trap build: no we, err=1; non-trap build: we with wa=0x0, upper half replaced, err=0; rst_n low during READ -> no we.

Source files
------------

// File: rtl/store_unit.sv
// Store unit: 2-entry request FIFO feeding a read-merge-write FSM for byte/half/word stores.
// Optional STORE_UNIT_MISALIGN_TRAP_EN drops misaligned half/word stores and raises a sticky err.

package store_unit_pkg;
    typedef enum logic [1:0] {
        LdstByte = 2'd0,
        LdstHalf = 2'd1,
        LdstWord = 2'd2
    } ldst_mode;
endpackage

module store_unit
    import store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_addr,
    input  ldst_mode    s_mode,
    input  logic [31:0] s_data,
    output logic [31:0] ra,
    input  logic [31:0] rd,
    output logic        we,
    output logic [31:0] wa,
    output ldst_mode    wm,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    typedef struct packed {
        logic [31:0] addr;
        ldst_mode    mode;
        logic [31:0] data;
    } req_t;

    req_t        fifo_q [2];
    logic        head_q;
    logic [1:0]  count_q, count_d;
    state_e      state_q, state_d;
    req_t        cur_q, cur_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] merged;
    logic        push, pop, drop;
    req_t        head_req, in_req;
    ldst_mode    mode_norm;

    // Unknown encodings are stored as word so the datapath only ever sees three modes.
    always_comb begin
        case (s_mode)
            LdstByte, LdstHalf: mode_norm = s_mode;
            default:            mode_norm = LdstWord;
        endcase
    end

    assign in_req   = '{addr: s_addr, mode: mode_norm, data: s_data};
    assign head_req = fifo_q[head_q];
    assign s_ready  = (count_q != 2'd2);
    assign push     = s_valid && s_ready;

`ifdef STORE_UNIT_MISALIGN_TRAP_EN
    logic misaligned;
    logic err_q;

    always_comb begin
        case (head_req.mode)
            LdstHalf: misaligned = head_req.addr[0];
            LdstWord: misaligned = |head_req.addr[1:0];
            default:  misaligned = 1'b0;
        endcase
    end

    assign drop = misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (pop && drop) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign drop = 1'b0;
    assign err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        merge_d = merge_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != 2'd0) begin
                    pop   = 1'b1;
                    cur_d = head_req;
                    if (drop) begin
                        state_d = StIdle;
                    end else if (head_req.mode == LdstWord) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                merge_d = rd;
                state_d = StWrite;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[head_q ^ count_q[0]] <= in_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
            state_q <= StIdle;
            cur_q   <= '0;
            merge_q <= '0;
        end else begin
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_d;
            state_q <= state_d;
            cur_q   <= cur_d;
            merge_q <= merge_d;
        end
    end

    always_comb begin
        merged = merge_q;
        case (cur_q.mode)
            LdstByte: merged[{cur_q.addr[1:0], 3'b000} +: 8] = cur_q.data[7:0];
            LdstHalf: merged[{cur_q.addr[1], 4'b0000} +: 16] = cur_q.data[15:0];
            default:  merged = cur_q.data;
        endcase
    end

    assign ra   = (state_q == StRead) ? {cur_q.addr[31:2], 2'b00} : 32'd0;
    assign we   = (state_q == StWrite);
    assign wa   = we ? {cur_q.addr[31:2], 2'b00} : 32'd0;
    assign wd   = we ? merged : 32'd0;
    assign wm   = LdstWord;
    assign done = we;
    assign busy = (count_q != 2'd0) || (state_q != StIdle);

endmodule

// File: tb/tb_store_unit.sv
// Randomized scoreboard bench for store_unit with a byte-lane memory reference model.
module tb_store_unit;
    import store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [1:0]  s_mode_raw;
    ldst_mode    s_mode;
    logic [31:0] s_data;
    logic [31:0] ra;
    logic [31:0] rd;
    logic        we;
    logic [31:0] wa;
    ldst_mode    wm;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    assign s_mode = ldst_mode'(s_mode_raw);

    store_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_mode  (s_mode),
        .s_data  (s_data),
        .ra      (ra),
        .rd      (rd),
        .we      (we),
        .wa      (wa),
        .wm      (wm),
        .wd      (wd),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // Bench-side memory: 256 words, addresses kept below 0x400.
    logic [31:0] mem [256];
    logic        mem_clr = 1'b0;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'd0;
    logic [31:0] poke_data = 32'd0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_data;
        end else if (we) begin
            mem[wa[9:2]] <= wd;
        end
    end

    assign rd = mem[ra[9:2]];

    typedef struct {
        logic [31:0] wa;
        logic [31:0] wd;
        bit          lat_chk;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [256];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse is matched against the oldest expected store.
    always @(negedge clk) begin
        exp_t e;
        if (we || done) chk("done_with_we", {31'd0, done}, {31'd0, we});
        if (we) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: wa=%h wd=%h with nothing pending", wa, wd);
            end else begin
                e = sb.pop_front();
                chk("wa", wa, e.wa);
                chk("wd", wd, e.wd);
                chk("wm", 32'(wm), 32'(LdstWord));
                if (e.lat_chk) chk("latency", cyc, e.exp_cyc);
            end
        end
    end

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [1:0] m, input logic [31:0] d);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (m == 2'd0) begin
            b[a[1:0]] = d[7:0];
        end else if (m == 2'd1) begin
            b[{a[1], 1'b0}] = d[7:0];
            b[{a[1], 1'b1}] = d[15:8];
        end else begin
            return d;
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] m);
        if (m == 2'd1) return a[0];
        if (m == 2'd2 || m == 2'd3) return a[1:0] != 2'd0;
        return 1'b0;
    endfunction

    task automatic accept_model(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d,
                                input bit lat);
        exp_t e;
        logic [31:0] nw;
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
        if (is_misaligned(a, m)) begin
            exp_err = 1'b1;
            return;
        end
`endif
        nw = ref_merge(ref_mem[a[9:2]], a, m, d);
        ref_mem[a[9:2]] = nw;
        e.wa      = {a[31:2], 2'b00};
        e.wd      = nw;
        e.lat_chk = lat;
        e.exp_cyc = cyc + ((m == 2'd0 || m == 2'd1) ? 3 : 2);
        sb.push_back(e);
    endtask

    // Call at a point after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d,
                        input bit lat);
        int n = 0;
        s_valid    = 1'b1;
        s_addr     = a;
        s_mode_raw = m;
        s_data     = d;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
        end else begin
            accept_model(a, m, d, lat);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: busy=%b pending=%0d required 0", busy, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_idx  = a[9:2];
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
        ref_mem[a[9:2]] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ra"}, ra, 32'd0);
        chk({tag, "_wa"}, wa, 32'd0);
        chk({tag, "_wd"}, wd, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        logic [31:0] a;
        logic [1:0]  m;
        s_valid    = 1'b0;
        s_addr     = 32'd0;
        s_mode_raw = 2'd0;
        s_data     = 32'd0;
        rst_n      = 1'b0;
        mem_clr    = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("post_reset");
        @(posedge clk);
        #1;

        // Word store into an idle unit.
        send(32'h0000_00FC, 2'd2, 32'h0012_3456, 1'b1);
        drain();
        chk("word_mem", mem[8'h3F], 32'h0012_3456);

        // Byte and half merges over a preloaded word.
        poke(32'h100, 32'h1122_3344);
        send(32'h0000_0101, 2'd0, 32'h0000_00AB, 1'b1);
        drain();
        chk("byte_merge_mem", mem[8'h40], 32'h1122_AB44);
        poke(32'h100, 32'h1122_3344);
        send(32'h0000_0102, 2'd1, 32'h0000_BEEF, 1'b1);
        drain();
        chk("half_merge_mem", mem[8'h40], 32'hBEEF_3344);

        // Three requests held back-to-back: FIFO fills and stalls the source.
        d0 = done_cnt;
        send(32'h200, 2'd0, 32'h11, 1'b0);
        send(32'h204, 2'd0, 32'h22, 1'b0);
        send(32'h208, 2'd0, 32'h33, 1'b0);
        chk("fifo_full_s_ready", {31'd0, s_ready}, 32'd0);
        chk("fifo_full_busy", {31'd0, busy}, 32'd1);
        drain();
        chk("three_done", done_cnt - d0, 32'd3);

        // Consecutive byte stores to the same word must read the earlier write.
        poke(32'h0, 32'h0);
        send(32'h0, 2'd0, 32'h01, 1'b0);
        send(32'h1, 2'd0, 32'h02, 1'b0);
        drain();
        chk("raw_same_word", mem[0], 32'h0000_0201);

        // Unknown mode encoding behaves as a word store.
        send(32'h300, 2'd3, 32'hDEAD_BEEF, 1'b1);
        drain();
        chk("mode3_word", mem[8'hC0], 32'hDEAD_BEEF);

        // Randomized stream against the reference model.
        for (int i = 0; i < 60; i++) begin
            a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            m = 2'($urandom_range(0, 3));
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
            if (m == 2'd1) a[0] = 1'b0;
            if (m >= 2'd2) a[1:0] = 2'b00;
`endif
            send(a, m, $urandom, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 4);
                repeat (n) @(posedge clk);
                #1;
            end
        end
        drain();
        for (int i = 0; i < 256; i += 17) chk("random_mem", mem[i], ref_mem[i]);
        chk("err_clear_before_misalign", {31'd0, err}, 32'd0);

        // Misaligned half store to 0x3.
        poke(32'h0, 32'h1122_3344);
        send(32'h3, 2'd1, 32'h0000_BEEF, 1'b0);
        drain();
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
        chk("trap_err", {31'd0, err}, {31'd0, exp_err});
        chk("trap_mem_kept", mem[0], 32'h1122_3344);
        send(32'h102, 2'd2, 32'h1234_5678, 1'b0);
        drain();
        chk("trap_err_sticky", {31'd0, err}, 32'd1);
`else
        chk("notrap_err", {31'd0, err}, 32'd0);
        chk("notrap_mem", mem[0], 32'hBEEF_3344);
`endif

        // Reset while a byte store sits in READ: the write must be abandoned.
        poke(32'h104, 32'hCAFE_F00D);
        send(32'h105, 2'd0, 32'h55, 1'b0);
        n = 0;
        @(negedge clk);
        while (ra != 32'h104 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_read", ra, 32'h104);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("abort");
        rst_n = 1'b1;
        ref_mem[8'h41] = 32'hCAFE_F00D;
        drain();
        chk("abort_mem_kept", mem[8'h41], 32'hCAFE_F00D);
        chk("abort_err_clear", {31'd0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
